// File: rtl/mac_bus_pkg.sv
// Shared constants, FSM encoding and helpers for the 68000 bus controller.
`timescale 1ns/1ps
package mac_bus_pkg;

  localparam logic [1:0] MODE_WAIT  = 2'd0;
  localparam logic [1:0] MODE_READY = 2'd1;
  localparam logic [1:0] MODE_VPA   = 2'd2;

  localparam logic [2:0]  FC_IACK     = 3'b111;
  localparam logic [23:0] OVERLAY_TOP = 24'h400000;

  // Region index width covers the largest supported region count (8).
  localparam int SEL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_RDY,
    ST_VPA,
    ST_ACK,
    ST_NOMAP,
    ST_BERR
  } bus_state_e;

  // States in which the bus-error timeout is running.
  function automatic logic is_pending(input bus_state_e st);
    return (st == ST_WAIT) || (st == ST_RDY) || (st == ST_NOMAP);
  endfunction

endpackage

// File: rtl/mac_region_match.sv
// Base/mask address comparators, one per region, with lowest-index priority.
`timescale 1ns/1ps
module mac_region_match
  import mac_bus_pkg::*;
#(
  parameter int                      c_regions = 4,
  parameter logic [24*c_regions-1:0] c_base    = '0,
  parameter logic [24*c_regions-1:0] c_mask    = '0
) (
  input  logic [23:0]          addr,
  output logic [c_regions-1:0] hit,
  output logic [SEL_W-1:0]     idx
);

  for (genvar g = 0; g < c_regions; g++) begin : g_cmp
    assign hit[g] = (addr & c_mask[24*g +: 24]) == c_base[24*g +: 24];
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    idx = '0;
    for (int i = c_regions - 1; i >= 0; i--) begin
      if (hit[i]) idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/mac_bus_ctrl.sv
// 68000 bus controller: region decode plus DTACKn/VPAn/BERRn sequencing,
// wait states, external-ready regions, autovector IACK, timeout and ROM overlay.
`timescale 1ns/1ps
module mac_bus_ctrl
  import mac_bus_pkg::*;
#(
  parameter int                      c_regions     = 4,
  parameter logic [24*c_regions-1:0] c_base        = {24'he00000, 24'h800000, 24'h400000, 24'h000000},
  parameter logic [24*c_regions-1:0] c_mask        = {24'he00000, 24'hc00000, 24'hc00000, 24'hc00000},
  parameter logic [2*c_regions-1:0]  c_mode        = {2'd2, 2'd0, 2'd0, 2'd1},
  parameter logic [4*c_regions-1:0]  c_waits       = {4'd0, 4'd3, 4'd1, 4'd0},
  parameter int                      c_overlay_rgn = 1,
  parameter int                      c_timeout     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_as_n,
  input  logic                 cpu_rw,
  input  logic                 cpu_uds_n,
  input  logic                 cpu_lds_n,
  input  logic [23:1]          cpu_a,
  input  logic [2:0]           cpu_fc,
  input  logic                 overlay_clr,
  input  logic [c_regions-1:0] rgn_ready,
  output logic [c_regions-1:0] rgn_cs,
  output logic                 rgn_we,
  output logic                 dtack_n,
  output logic                 vpa_n,
  output logic                 berr_n,
  output logic                 overlay,
  output logic [7:0]           timeout_cnt,
  output bus_state_e           dbg_state
);

  localparam int TW = $clog2(c_timeout + 1);

  // Handshake: a bus cycle opens when cpu_as_n is sampled low after being
  // sampled high; exactly one of dtack_n/vpa_n/berr_n may then go low and it
  // stays low until cpu_as_n is sampled high, which releases every output on
  // that same edge whether or not the cycle was acknowledged.

  bus_state_e           state, nxt;
  logic [23:0]          addr;
  logic                 as_prev;
  logic                 overlay_q;
  logic [3:0]           wcnt;
  logic [TW-1:0]        tcnt;
  logic [c_regions-1:0] hit;
  logic [c_regions-1:0] cs_q;
  logic [c_regions-1:0] dec_cs;
  logic                 we_q;
  logic [SEL_W-1:0]     match_idx;
  logic [SEL_W-1:0]     dec_sel;
  logic [1:0]           dec_mode;
  logic [3:0]           dec_wait;
  logic                 dec_valid;
  logic                 ovl_hit;
  logic                 iack;
  logic                 rdy;
  logic                 tmo;

  assign addr = {cpu_a, 1'b0};

  mac_region_match #(
    .c_regions (c_regions),
    .c_base    (c_base),
    .c_mask    (c_mask)
  ) u_match (
    .addr (addr),
    .hit  (hit),
    .idx  (match_idx)
  );

  // The overlay forces the ROM region for low addresses, masking any other hit.
  always_comb begin
    iack      = cpu_fc == FC_IACK;
    ovl_hit   = overlay_q && (addr < OVERLAY_TOP);
    dec_sel   = ovl_hit ? SEL_W'(c_overlay_rgn) : match_idx;
    dec_valid = ovl_hit || (|hit);
    dec_cs    = '0;
    dec_mode  = MODE_WAIT;
    dec_wait  = '0;
    for (int i = 0; i < c_regions; i++) begin
      if (dec_valid && (dec_sel == SEL_W'(i))) begin
        dec_cs[i] = 1'b1;
        dec_mode  = c_mode[2*i +: 2];
        dec_wait  = c_waits[4*i +: 4];
      end
    end
    rdy = |(rgn_ready & cs_q);
    tmo = tcnt == TW'(c_timeout - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (cpu_as_n) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:   if (as_prev) nxt = ST_DECODE;
        ST_DECODE: begin
          if (iack)            nxt = ST_VPA;
          else if (!dec_valid) nxt = ST_NOMAP;
          else begin
            case (dec_mode)
              MODE_WAIT:  nxt = ST_WAIT;
              MODE_READY: nxt = ST_RDY;
              MODE_VPA:   nxt = ST_VPA;
              default:    nxt = ST_NOMAP;
            endcase
          end
        end
        ST_WAIT: begin
          if (wcnt == 4'd0) nxt = ST_ACK;
          else if (tmo)     nxt = ST_BERR;
        end
        ST_RDY: begin
          if (rdy)      nxt = ST_ACK;
          else if (tmo) nxt = ST_BERR;
        end
        ST_NOMAP:  if (tmo) nxt = ST_BERR;
        ST_VPA, ST_ACK, ST_BERR: nxt = state;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dtack_n = state != ST_ACK;
    vpa_n   = state != ST_VPA;
    berr_n  = state != ST_BERR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      as_prev     <= 1'b0;
      overlay_q   <= 1'b1;
      wcnt        <= '0;
      tcnt        <= '0;
      cs_q        <= '0;
      we_q        <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      as_prev <= cpu_as_n;
      if (overlay_clr) overlay_q <= 1'b0;

      if (state == ST_DECODE)                    wcnt <= dec_wait;
      else if (state == ST_WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;

      if (state == ST_DECODE)                 tcnt <= '0;
      else if (is_pending(state) && !tmo)     tcnt <= tcnt + TW'(1);

      if (nxt == ST_IDLE) begin
        cs_q <= '0;
        we_q <= 1'b0;
      end else if (state == ST_DECODE && !iack) begin
        cs_q <= dec_cs;
        we_q <= dec_valid && !cpu_rw && !(cpu_uds_n && cpu_lds_n);
      end

      if (nxt == ST_BERR && state != ST_BERR && timeout_cnt != 8'hff)
        timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

  assign rgn_cs    = cs_q;
  assign rgn_we    = we_q;
  assign overlay   = overlay_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mac_bus_ctrl.sv
// Randomised scoreboard bench for mac_bus_ctrl with a region-table reference model.
`timescale 1ns/1ps
module tb_mac_bus_ctrl;
  import mac_bus_pkg::*;

  localparam int TIMEOUT = 255;
  localparam int LIMIT   = TIMEOUT + 20;

  localparam logic [23:0] T_BASE [4] = '{24'h000000, 24'h400000, 24'h800000, 24'he00000};
  localparam logic [23:0] T_MASK [4] = '{24'hc00000, 24'hc00000, 24'hc00000, 24'he00000};
  localparam int          T_MODE [4] = '{1, 0, 0, 2};
  localparam int          T_WAIT [4] = '{0, 1, 3, 0};

  typedef struct packed {
    logic [2:0]  strb;   // {berr_n, vpa_n, dtack_n}
    logic [15:0] lat;    // clocks from the edge sampling as_n low
    logic [3:0]  cs;
    logic        we;
    logic [7:0]  tcnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_as_n, cpu_rw, cpu_uds_n, cpu_lds_n, overlay_clr;
  logic [23:1] cpu_a;
  logic [2:0]  cpu_fc;
  logic [3:0]  rgn_ready;
  logic [3:0]  rgn_cs;
  logic        rgn_we, dtack_n, vpa_n, berr_n, overlay;
  logic [7:0]  timeout_cnt;
  bus_state_e  dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit m_overlay = 1'b1;
  int m_tcnt = 0;

  mac_bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_n    (cpu_as_n),
    .cpu_rw      (cpu_rw),
    .cpu_uds_n   (cpu_uds_n),
    .cpu_lds_n   (cpu_lds_n),
    .cpu_a       (cpu_a),
    .cpu_fc      (cpu_fc),
    .overlay_clr (overlay_clr),
    .rgn_ready   (rgn_ready),
    .rgn_cs      (rgn_cs),
    .rgn_we      (rgn_we),
    .dtack_n     (dtack_n),
    .vpa_n       (vpa_n),
    .berr_n      (berr_n),
    .overlay     (overlay),
    .timeout_cnt (timeout_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"},      32'(rgn_cs), 32'h0);
    check({tag, "_we"},      32'(rgn_we), 32'h0);
    check({tag, "_dtack"},   32'(dtack_n), 32'h1);
    check({tag, "_vpa"},     32'(vpa_n), 32'h1);
    check({tag, "_berr"},    32'(berr_n), 32'h1);
    check({tag, "_overlay"}, 32'(overlay), 32'h1);
    check({tag, "_tcnt"},    32'(timeout_cnt), 32'h0);
  endtask

  // Reference model: region table lookup, overlay rule and response timing.
  function automatic exp_t model(input logic [23:0] a, input logic rw, input logic [2:0] fc,
                                 input logic uds_n, input logic lds_n, input int rdy_at);
    exp_t e;
    int   rgn;
    int   l;
    e      = '0;
    e.tcnt = 8'(m_tcnt);
    if (fc == 3'b111) begin
      e.strb = 3'b101;
      e.lat  = 16'd1;
      return e;
    end
    rgn = -1;
    if (m_overlay && a < 24'h400000) rgn = 1;
    else
      for (int i = 3; i >= 0; i--)
        if ((a & T_MASK[i]) == T_BASE[i]) rgn = i;
    if (rgn < 0) begin
      e.strb = 3'b011;
      e.lat  = 16'(1 + TIMEOUT);
      e.tcnt = 8'((m_tcnt + 1 > 255) ? 255 : m_tcnt + 1);
      return e;
    end
    e.cs = 4'(1 << rgn);
    e.we = !rw && !(uds_n && lds_n);
    if (T_MODE[rgn] == 0) begin
      e.strb = 3'b110;
      e.lat  = 16'(2 + T_WAIT[rgn]);
    end else if (T_MODE[rgn] == 1) begin
      l = (rdy_at + 1 < 2) ? 2 : rdy_at + 1;
      if (l > 1 + TIMEOUT) begin
        e.strb = 3'b011;
        e.lat  = 16'(1 + TIMEOUT);
        e.tcnt = 8'((m_tcnt + 1 > 255) ? 255 : m_tcnt + 1);
      end else begin
        e.strb = 3'b110;
        e.lat  = 16'(l);
      end
    end else begin
      e.strb = 3'b101;
      e.lat  = 16'd1;
    end
    return e;
  endfunction

  // Driver: one 68000 bus cycle. abort_at >= 0 releases as_n after that edge
  // with no response expected.
  task automatic bus_cycle(input logic [23:0] a, input logic rw, input logic [2:0] fc,
                           input logic uds_n, input logic lds_n, input int rdy_at,
                           input int abort_at);
    exp_t e;
    bit   got;
    e = '0;
    if (abort_at < 0) begin
      e = model(a, rw, fc, uds_n, lds_n, rdy_at);
      exp_q.push_back(e);
      if (e.strb == 3'b011) m_tcnt = int'(e.tcnt);
    end
    @(negedge clk);
    cpu_a     = a[23:1];
    cpu_rw    = rw;
    cpu_fc    = fc;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    rgn_ready = {3'($urandom), 1'b0};
    cpu_as_n  = 1'b0;
    start_cyc = cyc + 1;
    got = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      @(posedge clk); #1;
      if (!(dtack_n && vpa_n && berr_n)) begin
        got = 1'b1;
        break;
      end
      if (k == abort_at) break;
      @(negedge clk);
      rgn_ready = (k >= rdy_at) ? 4'hf : {3'($urandom), 1'b0};
    end
    if (abort_at < 0) begin
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL no_response: addr %h got none expected strobes %b", a, e.strb);
      end else begin
        @(posedge clk); #1;
        check("resp_held", 32'({berr_n, vpa_n, dtack_n}), 32'(e.strb));
      end
    end
    @(negedge clk);
    cpu_as_n  = 1'b1;
    rgn_ready = '0;
    @(posedge clk); #1;
    check("release_strb", 32'({berr_n, vpa_n, dtack_n}), 32'h7);
    check("release_cs", 32'(rgn_cs), 32'h0);
    check("release_we", 32'(rgn_we), 32'h0);
    if (abort_at >= 0) check("abort_idle", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic random_cycle();
    logic [23:0] a;
    logic [2:0]  fc;
    a  = 24'($urandom) & 24'hfffffe;
    fc = ($urandom_range(0, 7) == 0) ? 3'b111 : 3'($urandom_range(5, 6));
    bus_cycle(a, 1'($urandom), fc, 1'($urandom), 1'($urandom), $urandom_range(0, 10), -1);
  endtask

  // Scoreboard monitor: pops an expectation whenever a response strobe falls.
  initial begin
    bit   prev_resp;
    bit   resp;
    exp_t e;
    prev_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      resp = !(dtack_n && vpa_n && berr_n);
      if (resp && !prev_resp && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got strobes %b expected none", {berr_n, vpa_n, dtack_n});
        end else begin
          e = exp_q.pop_front();
          check("strobes", 32'({berr_n, vpa_n, dtack_n}), 32'(e.strb));
          check("latency", 32'(cyc - start_cyc), 32'(e.lat));
          check("rgn_cs", 32'(rgn_cs), 32'(e.cs));
          check("rgn_we", 32'(rgn_we), 32'(e.we));
          check("timeout_cnt", 32'(timeout_cnt), 32'(e.tcnt));
        end
      end
      prev_resp = resp;
    end
  end

  initial begin
    #1_300_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1; cpu_as_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_a = '0; cpu_fc = 3'b101; overlay_clr = 1'b0; rgn_ready = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk); reset = 1'b0;

    // ROM through overlay
    bus_cycle(24'h000010, 1'b1, 3'b110, 1'b0, 1'b0, 0, -1);
    repeat (30) random_cycle();

    @(negedge clk); overlay_clr = 1'b1;
    @(negedge clk); overlay_clr = 1'b0; m_overlay = 1'b0;
    #1 check("overlay_clr", 32'(overlay), 32'h0);

    bus_cycle(24'h000010, 1'b1, 3'b110, 1'b0, 1'b0, 5, -1);
    bus_cycle(24'h800000, 1'b0, 3'b101, 1'b0, 1'b0, 0, -1);
    bus_cycle(24'hefe1fe, 1'b1, 3'b101, 1'b0, 1'b1, 0, -1);
    bus_cycle(24'hfffff2, 1'b1, 3'b111, 1'b1, 1'b0, 0, -1);
    bus_cycle(24'hc00000, 1'b1, 3'b101, 1'b0, 1'b0, 0, -1);
    bus_cycle(24'h000100, 1'b1, 3'b110, 1'b0, 1'b0, 1000, 4);
    bus_cycle(24'h400020, 1'b0, 3'b101, 1'b1, 1'b1, 0, -1);
    repeat (90) random_cycle();

    // Drive enough unmapped cycles that the BERR count saturates.
    while (m_tcnt < 255) bus_cycle(24'hc00000, 1'b1, 3'b101, 1'b0, 1'b0, 0, -1);
    bus_cycle(24'hd00000, 1'b1, 3'b101, 1'b0, 1'b0, 0, -1);
    check("tcnt_saturated", 32'(timeout_cnt), 32'(m_tcnt));

    // Reset asserted in the middle of a region-2 wait sequence.
    @(negedge clk);
    cpu_a = 23'(24'h800000 >> 1); cpu_rw = 1'b1; cpu_fc = 3'b101;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_as_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midwait_reset");
    @(negedge clk);
    reset = 1'b0; cpu_as_n = 1'b1;
    m_overlay = 1'b1; m_tcnt = 0;

    bus_cycle(24'h000010, 1'b1, 3'b110, 1'b0, 1'b0, 0, -1);
    repeat (10) random_cycle();

    repeat (4) @(posedge clk);
    #1 check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
